// File: rtl/insight_dcache_txn_tracker.sv
// Observational DCache transaction tracker: per-tag latency, timeouts, dup/orphan errors, counters.
// Optional max-latency capture is enabled by defining INSIGHT_DCACHE_TRACKER_MAXLAT_EN.
module insight_dcache_txn_tracker #(
  parameter int NUM_TAGS = 8,
  parameter int TAG_W    = 3,
  parameter int ADDR_W   = 40,
  parameter int LAT_W    = 12,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  // req/resp are valid-only strobes sampled on every edge where valid is high; there is
  // no ready, the tracker never stalls the cache.
  input  logic                req_valid,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_is_store,
  input  logic                resp_valid,
  input  logic [TAG_W-1:0]    resp_tag,
  output logic                lat_valid,
  output logic [TAG_W-1:0]    lat_tag,
  output logic [ADDR_W-1:0]   lat_addr,
  output logic                lat_is_store,
  output logic [LAT_W-1:0]    lat_cycles,
  output logic [NUM_TAGS-1:0] timeout_vec,
  output logic                err_dup_req,
  output logic                err_orphan_resp,
  output logic [TAG_W:0]      outstanding,
  output logic [CNT_W-1:0]    req_count,
  output logic [CNT_W-1:0]    resp_count
`ifdef INSIGHT_DCACHE_TRACKER_MAXLAT_EN
  ,
  output logic [LAT_W-1:0]    max_lat,
  output logic [TAG_W-1:0]    max_lat_tag,
  input  logic                max_lat_clr
`endif
);

  localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [NUM_TAGS-1:0] valid_q, valid_d, to_q, to_d, store_q, store_d, tv_q, tv_d;
  logic [LAT_W-1:0]    age_q  [NUM_TAGS];
  logic [LAT_W-1:0]    age_d  [NUM_TAGS];
  logic [ADDR_W-1:0]   addr_q [NUM_TAGS];
  logic [ADDR_W-1:0]   addr_d [NUM_TAGS];

  logic                lat_valid_q, lat_valid_d, lat_store_q, lat_store_d;
  logic [TAG_W-1:0]    lat_tag_q, lat_tag_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [LAT_W-1:0]    lat_cyc_q, lat_cyc_d;
  logic                dup_q, dup_d, orphan_q, orphan_d;
  logic [TAG_W:0]      out_q, out_d;
  logic [CNT_W-1:0]    req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
  logic                resp_hit;

  assign resp_hit = resp_valid && valid_q[resp_tag];

  // Slot update: retire before allocate, so a same-tag req+resp reports the old entry and restarts.
  always_comb begin
    valid_d = valid_q;
    to_d    = to_q;
    store_d = store_q;
    tv_d    = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      addr_d[i] = addr_q[i];
      age_d[i]  = age_q[i];
      if (valid_q[i] && age_q[i] != LAT_MAX) age_d[i] = age_q[i] + LAT_W'(1);
      if (TIMEOUT != 0 && valid_q[i] && !to_q[i] && age_q[i] == TIMEOUT_L) begin
        tv_d[i] = 1'b1;
        to_d[i] = 1'b1;
      end
    end
    if (resp_hit) valid_d[resp_tag] = 1'b0;
    if (req_valid) begin
      valid_d[req_tag] = 1'b1;
      to_d[req_tag]    = 1'b0;
      age_d[req_tag]   = LAT_W'(1);
      addr_d[req_tag]  = req_addr;
      store_d[req_tag] = req_is_store;
    end
  end

  always_comb begin
    lat_valid_d = resp_hit;
    lat_tag_d   = lat_tag_q;
    lat_addr_d  = lat_addr_q;
    lat_store_d = lat_store_q;
    lat_cyc_d   = lat_cyc_q;
    if (resp_hit) begin
      lat_tag_d   = resp_tag;
      lat_addr_d  = addr_q[resp_tag];
      lat_store_d = store_q[resp_tag];
      lat_cyc_d   = age_q[resp_tag];
    end
    dup_d    = req_valid && valid_q[req_tag] && !(resp_hit && resp_tag == req_tag);
    orphan_d = resp_valid && !valid_q[resp_tag];
    out_d    = '0;
    for (int i = 0; i < NUM_TAGS; i++) out_d = out_d + {{TAG_W{1'b0}}, valid_d[i]};
    req_cnt_d  = (req_valid && req_cnt_q != CNT_MAX) ? req_cnt_q + CNT_W'(1) : req_cnt_q;
    resp_cnt_d = (resp_hit && resp_cnt_q != CNT_MAX) ? resp_cnt_q + CNT_W'(1) : resp_cnt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      to_q        <= '0;
      store_q     <= '0;
      tv_q        <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        age_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      lat_valid_q <= 1'b0;
      lat_tag_q   <= '0;
      lat_addr_q  <= '0;
      lat_store_q <= 1'b0;
      lat_cyc_q   <= '0;
      dup_q       <= 1'b0;
      orphan_q    <= 1'b0;
      out_q       <= '0;
      req_cnt_q   <= '0;
      resp_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      to_q        <= to_d;
      store_q     <= store_d;
      tv_q        <= tv_d;
      for (int i = 0; i < NUM_TAGS; i++) begin
        age_q[i]  <= age_d[i];
        addr_q[i] <= addr_d[i];
      end
      lat_valid_q <= lat_valid_d;
      lat_tag_q   <= lat_tag_d;
      lat_addr_q  <= lat_addr_d;
      lat_store_q <= lat_store_d;
      lat_cyc_q   <= lat_cyc_d;
      dup_q       <= dup_d;
      orphan_q    <= orphan_d;
      out_q       <= out_d;
      req_cnt_q   <= req_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
    end
  end

  assign lat_valid       = lat_valid_q;
  assign lat_tag         = lat_tag_q;
  assign lat_addr        = lat_addr_q;
  assign lat_is_store    = lat_store_q;
  assign lat_cycles      = lat_cyc_q;
  assign timeout_vec     = tv_q;
  assign err_dup_req     = dup_q;
  assign err_orphan_resp = orphan_q;
  assign outstanding     = out_q;
  assign req_count       = req_cnt_q;
  assign resp_count      = resp_cnt_q;

`ifdef INSIGHT_DCACHE_TRACKER_MAXLAT_EN
  logic [LAT_W-1:0] max_lat_q, max_lat_d;
  logic [TAG_W-1:0] max_tag_q, max_tag_d;

  // Strict greater-than keeps the older tag on ties; a coincident clear takes the new report.
  always_comb begin
    max_lat_d = max_lat_q;
    max_tag_d = max_tag_q;
    if (max_lat_clr) begin
      max_lat_d = '0;
      max_tag_d = '0;
    end
    if (lat_valid_q && (max_lat_clr || lat_cyc_q > max_lat_q)) begin
      max_lat_d = lat_cyc_q;
      max_tag_d = lat_tag_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      max_lat_q <= '0;
      max_tag_q <= '0;
    end else begin
      max_lat_q <= max_lat_d;
      max_tag_q <= max_tag_d;
    end
  end

  assign max_lat     = max_lat_q;
  assign max_lat_tag = max_tag_q;
`endif

endmodule

// File: tb/tb_insight_dcache_txn_tracker.sv
// Bench for insight_dcache_txn_tracker: issue-time reference model, scoreboard queue for reports.
module tb_insight_dcache_txn_tracker;
  localparam int NT = 8;
  localparam int TW = 3;
  localparam int AW = 40;
  localparam int LW = 5;
  localparam int TO = 16;
  localparam int CW = 6;
  localparam int LMAX = (1 << LW) - 1;
  localparam int CMAX = (1 << CW) - 1;
  localparam int EXP_W = TW + AW + 1 + LW;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic [TW-1:0] req_tag;
  logic [AW-1:0] req_addr;
  logic          req_is_store;
  logic          resp_valid;
  logic [TW-1:0] resp_tag;
  logic          lat_valid;
  logic [TW-1:0] lat_tag;
  logic [AW-1:0] lat_addr;
  logic          lat_is_store;
  logic [LW-1:0] lat_cycles;
  logic [NT-1:0] timeout_vec;
  logic          err_dup_req;
  logic          err_orphan_resp;
  logic [TW:0]   outstanding;
  logic [CW-1:0] req_count;
  logic [CW-1:0] resp_count;
`ifdef INSIGHT_DCACHE_TRACKER_MAXLAT_EN
  logic [LW-1:0] max_lat;
  logic [TW-1:0] max_lat_tag;
  logic          max_lat_clr;
  initial max_lat_clr = 1'b0;
`endif

  insight_dcache_txn_tracker #(
    .NUM_TAGS(NT), .TAG_W(TW), .ADDR_W(AW), .LAT_W(LW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_tag(req_tag), .req_addr(req_addr), .req_is_store(req_is_store),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
    .lat_valid(lat_valid), .lat_tag(lat_tag), .lat_addr(lat_addr), .lat_is_store(lat_is_store),
    .lat_cycles(lat_cycles), .timeout_vec(timeout_vec), .err_dup_req(err_dup_req),
    .err_orphan_resp(err_orphan_resp), .outstanding(outstanding),
    .req_count(req_count), .resp_count(resp_count)
`ifdef INSIGHT_DCACHE_TRACKER_MAXLAT_EN
    , .max_lat(max_lat), .max_lat_tag(max_lat_tag), .max_lat_clr(max_lat_clr)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic             m_valid [NT];
  int               m_issue [NT];
  logic [AW-1:0]    m_addr  [NT];
  logic             m_st    [NT];
  int               edge_n = 0;
  logic [NT-1:0]    exp_tv = '0;
  logic             exp_dup = 1'b0;
  logic             exp_orph = 1'b0;
  int               exp_out = 0;
  int               exp_reqc = 0;
  int               exp_respc = 0;
  logic [EXP_W-1:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    int lat;
    int cnt;
    if (!reset_n) begin
      for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
      exp_tv = '0; exp_dup = 1'b0; exp_orph = 1'b0;
      exp_out = 0; exp_reqc = 0; exp_respc = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      exp_tv = '0; exp_dup = 1'b0; exp_orph = 1'b0;
      for (int i = 0; i < NT; i++)
        if (m_valid[i] && TO != 0 && edge_n - m_issue[i] == TO) exp_tv[i] = 1'b1;
      if (resp_valid) begin
        if (m_valid[resp_tag]) begin
          lat = edge_n - m_issue[resp_tag];
          if (lat > LMAX) lat = LMAX;
          exp_q.push_back({resp_tag, m_addr[resp_tag], m_st[resp_tag], LW'(lat)});
          m_valid[resp_tag] = 1'b0;
          if (exp_respc < CMAX) exp_respc++;
        end else begin
          exp_orph = 1'b1;
        end
      end
      if (req_valid) begin
        if (m_valid[req_tag]) exp_dup = 1'b1;
        m_valid[req_tag] = 1'b1;
        m_issue[req_tag] = edge_n;
        m_addr[req_tag]  = req_addr;
        m_st[req_tag]    = req_is_store;
        if (exp_reqc < CMAX) exp_reqc++;
      end
      cnt = 0;
      for (int i = 0; i < NT; i++) if (m_valid[i]) cnt++;
      exp_out = cnt;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int last_lat = 0;
  int tv4_cnt = 0;
  int orphan_cnt = 0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    chk("timeout_vec", 64'(timeout_vec), 64'(exp_tv));
    chk("err_dup_req", 64'(err_dup_req), 64'(exp_dup));
    chk("err_orphan_resp", 64'(err_orphan_resp), 64'(exp_orph));
    chk("outstanding", 64'(outstanding), 64'(exp_out));
    chk("req_count", 64'(req_count), 64'(exp_reqc));
    chk("resp_count", 64'(resp_count), 64'(exp_respc));
    if (lat_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lat_unexpected: got lat_valid=1 tag %0d, expected no report at %0t", lat_tag, $time);
      end else begin
        e = exp_q.pop_front();
        chk("lat_tag", 64'(lat_tag), 64'(e[EXP_W-1 -: TW]));
        chk("lat_addr", 64'(lat_addr), 64'(e[LW+1 +: AW]));
        chk("lat_is_store", 64'(lat_is_store), 64'(e[LW]));
        chk("lat_cycles", 64'(lat_cycles), 64'(e[LW-1:0]));
      end
      last_lat = int'(lat_cycles);
    end
    chk("lat_pending", 64'(exp_q.size()), 64'd0);
    if (timeout_vec[4]) tv4_cnt++;
    if (err_orphan_resp) orphan_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rv, input int rt, input logic [AW-1:0] ra, input logic rs,
                       input logic pv, input int pt);
    @(negedge clk);
    req_valid = rv; req_tag = TW'(rt); req_addr = ra; req_is_store = rs;
    resp_valid = pv; resp_tag = TW'(pt);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, '0, 1'b0, 1'b0, 0);
  endtask

  task automatic req(input int t, input logic [AW-1:0] a, input logic s);
    drive(1'b1, t, a, s, 1'b0, 0);
  endtask

  task automatic resp(input int t);
    drive(1'b0, 0, '0, 1'b0, 1'b1, t);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    reset_n = 1'b1;
    req_valid = 1'b0; req_tag = '0; req_addr = '0; req_is_store = 1'b0;
    resp_valid = 1'b0; resp_tag = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outstanding", 64'(outstanding), 64'd0);
    chk("reset_req_count", 64'(req_count), 64'd0);
    #1 reset_n = 1'b1;

    // basic latency: 5 edges from request to response
    idle(2);
    req(3, 40'h80001000, 1'b0);
    idle(4);
    resp(3);
    idle(2);
    chk("basic_lat", 64'(last_lat), 64'd5);
    chk("basic_resp_count", 64'(resp_count), 64'd1);

    // fill all tags, drain in reverse
    for (int i = 0; i < NT; i++) req(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    idle(2);
    chk("fill_outstanding", 64'(outstanding), 64'd8);
    for (int i = NT - 1; i >= 0; i--) resp(i);
    idle(2);
    chk("drain_outstanding", 64'(outstanding), 64'd0);

    // same-cycle req+resp on an outstanding tag
    req(2, 40'h12345, 1'b1);
    idle(9);
    drive(1'b1, 2, 40'h6789a, 1'b0, 1'b1, 2);
    idle(2);
    chk("collide_lat", 64'(last_lat), 64'd10);
    chk("collide_outstanding", 64'(outstanding), 64'd1);
    resp(2);
    idle(2);

    // orphan response and duplicate request
    base = orphan_cnt;
    resp(5);
    idle(2);
    chk("orphan_pulses", 64'(orphan_cnt - base), 64'd1);
    req(1, 40'h100, 1'b0);
    req(1, 40'h200, 1'b1);
    idle(2);
    chk("dup_outstanding", 64'(outstanding), 64'd1);
    resp(1);
    idle(2);

    // timeout pulse once, latency saturates at LMAX
    base = tv4_cnt;
    req(4, 40'h4444, 1'b0);
    idle(39);
    resp(4);
    idle(2);
    chk("timeout_pulses", 64'(tv4_cnt - base), 64'd1);
    chk("sat_lat", 64'(last_lat), 64'(LMAX));

    // asynchronous reset with transactions in flight
    req(0, 40'h10, 1'b0);
    req(1, 40'h20, 1'b1);
    req(2, 40'h30, 1'b0);
    idle(2);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_req_count", 64'(req_count), 64'd0);
    chk("midrst_lat_valid", 64'(lat_valid), 64'd0);
    chk("midrst_lat_addr", 64'(lat_addr), 64'd0);
    idle(2);
    @(posedge clk);
    #2 reset_n = 1'b1;
    base = orphan_cnt;
    resp(0);
    resp(1);
    resp(2);
    idle(2);
    chk("postrst_orphans", 64'(orphan_cnt - base), 64'd3);

    // randomized traffic
    for (int c = 0; c < 2000; c++)
      drive(1'($urandom_range(0, 99) < 40), int'($urandom_range(0, NT - 1)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 45), int'($urandom_range(0, NT - 1)));
    idle(40);
    chk("req_count_sat", 64'(req_count), 64'(CMAX));

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/insight_dcache_txn_tracker.md
Name: insight_dcache_txn_tracker

Overview:
- Parametrised successor to the per-hart DCache insight trace, which carries separate req and resp channels only.
- Tracks every committed DCache request by tag until its response arrives.
- Reports per-transaction latency, timeouts, duplicate-tag and orphan-response errors, plus saturating request/response counts.
- Sits beside the hart insight port and feeds trace/debug logic; purely observational, never back-pressures the cache.

Parameters:
- NUM_TAGS, 8, outstanding-request slots; power of two, 2..32.
- TAG_W, 3, tag width; equals log2(NUM_TAGS).
- ADDR_W, 40, request address width.
- LAT_W, 12, latency counter width; saturating.
- TIMEOUT, 1024, age that raises a timeout pulse; 0 disables timeouts; must be <= 2^LAT_W-1.
- CNT_W, 32, statistics counter width; saturating.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  commit-stage DCache request issued this cycle.
- req_tag  in  TAG_W  request tag.
- req_addr  in  ADDR_W  request address.
- req_is_store  in  1  1 = store/AMO, 0 = load.
- resp_valid  in  1  response for an earlier request.
- resp_tag  in  TAG_W  response tag.
- lat_valid  out  1  one-cycle pulse; a transaction completed.
- lat_tag  out  TAG_W  completed tag.
- lat_addr  out  ADDR_W  address captured at request.
- lat_is_store  out  1  type captured at request.
- lat_cycles  out  LAT_W  request-to-response cycles, saturating.
- timeout_vec  out  NUM_TAGS  per-tag one-cycle timeout pulses.
- err_dup_req  out  1  pulse; request hit an already-outstanding tag.
- err_orphan_resp  out  1  pulse; response to a non-outstanding tag.
- outstanding  out  TAG_W+1  number of valid slots.
- req_count  out  CNT_W  accepted requests, saturating.
- resp_count  out  CNT_W  matched responses, saturating.

Behaviour:
- Reset: all outputs 0; slot valid bits, ages and counters are 0. Assertion mid-operation clears everything immediately; in-flight transactions are discarded and produce no report.
- Slot state: valid, timed_out, age[LAT_W], addr, is_store.
- Allocation: req_valid at edge t sets valid, loads age=1, captures addr/is_store.
- Ageing: age then increments each edge, saturating at 2^LAT_W-1.
- Retire: a response at cycle t+k matches a slot with age k and clears valid.
- Reporting: lat_* registered; lat_valid is asserted at cycle t+k+1, lat_cycles=k (saturated value if overflowed).
- Same cycle, same tag, req and resp on a valid slot: the resp retires the old entry and is reported; the req allocates fresh. No dup error is raised.
- Same cycle, same tag, req and resp on an invalid slot: the req allocates and err_orphan_resp pulses, because a response cannot match a request issued in the same cycle.
- Duplicate request (req on a valid tag, no retiring resp): err_dup_req pulses next cycle; the slot is overwritten (age=1, new addr); req_count still increments.
- Orphan response: err_orphan_resp pulses next cycle; no lat_valid; resp_count unchanged.
- Timeout: when a valid, not timed_out slot's age becomes TIMEOUT, timeout_vec[i] pulses for one cycle and timed_out is set. The slot stays valid; a later response still reports normally. Multiple slots may pulse in the same cycle.
- outstanding: registered popcount of valid bits; it is full at NUM_TAGS, and a dup request does not increase it.
- Counters: saturate at all-ones and never wrap.
- All error and report outputs are registered, so there is a single cycle of latency after the triggering edge.

Optional Feature:
- Macro: INSIGHT_DCACHE_TRACKER_MAXLAT_EN.
- With the macro defined, adds ports max_lat out LAT_W, max_lat_tag out TAG_W and max_lat_clr in 1.
  - On each lat_valid, max_lat updates if lat_cycles > max_lat; ties keep the older tag.
  - max_lat_clr zeroes both registers; if clr and a report coincide, the register loads the new report value.
- Without the macro, those ports and registers are absent and all other behaviour is identical.

Test Plan:
- Basic latency: req tag 3 addr 0x80001000 load at cycle 10, resp tag 3 at cycle 15 -> lat_valid at 16, lat_cycles=5, lat_addr=0x80001000, outstanding returns 1->0, req_count=resp_count=1.
- Fill: 8 reqs on tags 0..7 in back-to-back cycles -> outstanding=8. Responses in reverse order -> eight lat pulses with correct per-tag latencies, final outstanding=0.
- Same-cycle collision: tag 2 outstanding since cycle 20; req+resp tag 2 at cycle 30 -> lat_cycles=10, no err_dup_req, slot 2 still valid with age restarted.
- Errors: resp tag 5 never requested -> err_orphan_resp pulse, resp_count unchanged. Second req on outstanding tag 1 -> err_dup_req pulse, outstanding unchanged.
- Timeout, TIMEOUT=16: req tag 4 at cycle 0 -> timeout_vec[4] pulses exactly once at cycle 17. Resp at cycle 40 -> lat_cycles=40. With LAT_W=4 the reported latency saturates at 15.
- Reset mid-flight: three outstanding tags, then reset_n low asynchronously between edges -> all outputs 0 immediately. After release, responses to those tags produce err_orphan_resp.
